// File: rtl/chu_mmio_bridge.sv
// Registered MMIO bridge: FPro bus to N_SLOT I/O slots with populated-slot mask,
// acknowledge-driven wait states, bus-timeout watchdog and saturating error counter.
module chu_mmio_bridge #(
  parameter int              N_SLOT     = 64,
  parameter int              REG_AW     = 5,
  parameter int              DW         = 32,
  parameter logic [63:0]     SLOT_MASK  = 64'h0000_0000_0000_03FF,
  parameter int              TIMEOUT    = 16,
  parameter logic [DW-1:0]   EMPTY_DATA = 32'hFFFF_FFFF,
  localparam int             SLOT_AW    = $clog2(N_SLOT),
  localparam int             AW         = SLOT_AW + REG_AW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mmio_cs_i,
  input  logic                 mmio_rd_i,
  input  logic                 mmio_wr_i,
  input  logic [AW-1:0]        mmio_addr_i,
  input  logic [DW-1:0]        mmio_wr_data_i,
  output logic [DW-1:0]        mmio_rd_data_o,
  output logic                 mmio_ready_o,
  output logic                 mmio_done_o,
  output logic                 mmio_err_o,
  output logic [7:0]           err_count_o,
  output logic [N_SLOT-1:0]    slot_cs_o,
  output logic [N_SLOT-1:0]    slot_rd_o,
  output logic [N_SLOT-1:0]    slot_wr_o,
  output logic [REG_AW-1:0]    slot_reg_addr_o,
  output logic [DW-1:0]        slot_wr_data_o,
  input  logic [N_SLOT*DW-1:0] slot_rd_data_i,
  input  logic [N_SLOT-1:0]    slot_ack_i
);

  // Elaboration-time guard on parameter ranges
  generate
    if (N_SLOT < 2 || N_SLOT > 64 || (1 << SLOT_AW) != N_SLOT) begin : g_bad_nslot
      $error("chu_mmio_bridge: N_SLOT must be a power of 2 in 2..64");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("chu_mmio_bridge: TIMEOUT must be in 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [SLOT_AW-1:0]  idx_q, idx_d;
  logic [REG_AW-1:0]   reg_q, reg_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic                is_rd_q, is_rd_d;
  logic [7:0]          timer_q, timer_d;
  logic [DW-1:0]       rd_data_q, rd_data_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic [N_SLOT-1:0]   populated;
  logic [DW-1:0]       rd_arr [N_SLOT];
  logic [SLOT_AW-1:0]  req_slot;
  logic                req_valid;
  logic                ack_sel;
  logic                access_active;

  assign populated = SLOT_MASK[N_SLOT-1:0];
  assign req_slot  = mmio_addr_i[AW-1:REG_AW];
  assign req_valid = mmio_cs_i & (mmio_rd_i ^ mmio_wr_i);
  assign ack_sel   = slot_ack_i[idx_q];

  generate
    for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_rd_unpack
      assign rd_arr[gi] = slot_rd_data_i[gi*DW +: DW];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      is_rd_q   <= 1'b0;
      timer_q   <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      is_rd_q   <= is_rd_d;
      timer_q   <= timer_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    is_rd_d   = is_rd_q;
    timer_d   = timer_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (req_valid) begin
          idx_d   = req_slot;
          reg_d   = mmio_addr_i[REG_AW-1:0];
          wdata_d = mmio_wr_data_i;
          is_rd_d = mmio_rd_i;
          if (populated[req_slot]) begin
            state_d = ST_ISSUE;
          end else begin
            // Unpopulated slot completes immediately without touching the slot bus
            state_d = ST_DONE;
            if (mmio_rd_i) rd_data_d = EMPTY_DATA;
          end
        end
      end

      ST_ISSUE: begin
        if (ack_sel) begin
          if (is_rd_q) rd_data_d = rd_arr[idx_q];
          state_d = ST_DONE;
        end else begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Ack is checked first so it wins over a simultaneous timeout
        if (ack_sel) begin
          if (is_rd_q) rd_data_d = rd_arr[idx_q];
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (timer_q == TIMER_LAST) begin
          if (is_rd_q) rd_data_d = EMPTY_DATA;
          err_d   = 1'b1;
          state_d = ST_DONE;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes decode from registered state only, so reset removes them at once
  assign access_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  generate
    for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_slot_strobe
      logic sel;
      assign sel            = access_active && (idx_q == SLOT_AW'(gi));
      assign slot_cs_o[gi]  = sel;
      assign slot_rd_o[gi]  = sel && (state_q == ST_ISSUE) && is_rd_q;
      assign slot_wr_o[gi]  = sel && (state_q == ST_ISSUE) && !is_rd_q;
    end
  endgenerate

  assign slot_reg_addr_o = reg_q;
  assign slot_wr_data_o  = wdata_q;
  assign mmio_rd_data_o  = rd_data_q;
  assign mmio_ready_o    = (state_q == ST_IDLE);
  assign mmio_done_o     = (state_q == ST_DONE);
  assign mmio_err_o      = (state_q == ST_DONE) && err_q;
  assign err_count_o     = err_cnt_q;

endmodule

// File: tb/tb_chu_mmio_bridge.sv
// Directed bench for chu_mmio_bridge: zero-wait, wait-state, timeout, unpopulated,
// illegal-request and mid-access reset scenarios with hand-computed expectations.
module tb_chu_mmio_bridge;

  localparam int N_SLOT = 64;
  localparam int REG_AW = 5;
  localparam int DW     = 32;
  localparam int AW     = 11;

  logic                 clk;
  logic                 rst_n;
  logic                 mmio_cs;
  logic                 mmio_rd;
  logic                 mmio_wr;
  logic [AW-1:0]        mmio_addr;
  logic [DW-1:0]        mmio_wr_data;
  logic [DW-1:0]        mmio_rd_data;
  logic                 mmio_ready;
  logic                 mmio_done;
  logic                 mmio_err;
  logic [7:0]           err_count;
  logic [N_SLOT-1:0]    slot_cs;
  logic [N_SLOT-1:0]    slot_rd;
  logic [N_SLOT-1:0]    slot_wr;
  logic [REG_AW-1:0]    slot_reg_addr;
  logic [DW-1:0]        slot_wr_data;
  logic [N_SLOT*DW-1:0] slot_rd_data;
  logic [N_SLOT-1:0]    slot_ack;

  int checks = 0;
  int errors = 0;

  chu_mmio_bridge dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .mmio_cs_i       (mmio_cs),
    .mmio_rd_i       (mmio_rd),
    .mmio_wr_i       (mmio_wr),
    .mmio_addr_i     (mmio_addr),
    .mmio_wr_data_i  (mmio_wr_data),
    .mmio_rd_data_o  (mmio_rd_data),
    .mmio_ready_o    (mmio_ready),
    .mmio_done_o     (mmio_done),
    .mmio_err_o      (mmio_err),
    .err_count_o     (err_count),
    .slot_cs_o       (slot_cs),
    .slot_rd_o       (slot_rd),
    .slot_wr_o       (slot_wr),
    .slot_reg_addr_o (slot_reg_addr),
    .slot_wr_data_o  (slot_wr_data),
    .slot_rd_data_i  (slot_rd_data),
    .slot_ack_i      (slot_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic rd, input logic [5:0] slot, input logic [4:0] rg,
                         input logic [31:0] wd);
    mmio_cs      = 1'b1;
    mmio_rd      = rd;
    mmio_wr      = ~rd;
    mmio_addr    = {slot, rg};
    mmio_wr_data = wd;
    tick();
    mmio_cs = 1'b0;
    mmio_rd = 1'b0;
    mmio_wr = 1'b0;
  endtask

  // Read of non-acking slot 0: 17 cycles to DONE, then back to IDLE
  task automatic timeout_read();
    request(1'b1, 6'd0, 5'd0, 32'h0);
    repeat (17) tick();
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    mmio_cs      = 1'b0;
    mmio_rd      = 1'b0;
    mmio_wr      = 1'b0;
    mmio_addr    = '0;
    mmio_wr_data = '0;
    slot_rd_data = '0;
    slot_ack     = '0;
    slot_rd_data[3*32 +: 32] = 32'h1234_5678;
    slot_rd_data[0*32 +: 32] = 32'hCAFE_0000;
    slot_rd_data[5*32 +: 32] = 32'h5555_AAAA;

    tick();
    tick();
    chk("reset_ready", 64'(mmio_ready), 64'd1);
    chk("reset_done", 64'(mmio_done), 64'd0);
    chk("reset_err", 64'(mmio_err), 64'd0);
    chk("reset_rd_data", 64'(mmio_rd_data), 64'd0);
    chk("reset_err_count", 64'(err_count), 64'd0);
    chk("reset_slot_cs", slot_cs, 64'd0);
    rst_n = 1'b1;
    tick();

    // Zero-wait read: slot 3, reg 5
    request(1'b1, 6'd3, 5'd5, 32'h0);
    chk("zw_slot_cs", slot_cs, 64'h8);
    chk("zw_slot_rd", slot_rd, 64'h8);
    chk("zw_slot_wr", slot_wr, 64'h0);
    chk("zw_reg_addr", 64'(slot_reg_addr), 64'd5);
    chk("zw_ready_busy", 64'(mmio_ready), 64'd0);
    chk("zw_done_c1", 64'(mmio_done), 64'd0);
    slot_ack[3] = 1'b1;
    tick();
    slot_ack[3] = 1'b0;
    chk("zw_done_c2", 64'(mmio_done), 64'd1);
    chk("zw_err", 64'(mmio_err), 64'd0);
    chk("zw_rd_data", 64'(mmio_rd_data), 64'h1234_5678);
    chk("zw_rd_strobe_off", slot_rd, 64'h0);
    tick();
    chk("zw_idle_ready", 64'(mmio_ready), 64'd1);
    chk("zw_idle_done", 64'(mmio_done), 64'd0);

    // Wait-state write: slot 9, reg 2, ack in 3rd WAIT cycle
    request(1'b0, 6'd9, 5'd2, 32'hA5A5_0001);
    chk("ws_slot_wr", slot_wr, 64'h200);
    chk("ws_slot_cs_c1", slot_cs, 64'h200);
    chk("ws_wr_data", 64'(slot_wr_data), 64'hA5A5_0001);
    chk("ws_reg_addr", 64'(slot_reg_addr), 64'd2);
    tick();
    chk("ws_wr_strobe_off", slot_wr, 64'h0);
    chk("ws_slot_cs_c2", slot_cs, 64'h200);
    tick();
    chk("ws_slot_cs_c3", slot_cs, 64'h200);
    // Request and foreign ack during WAIT must both be ignored
    mmio_cs   = 1'b1;
    mmio_rd   = 1'b1;
    mmio_addr = {6'd3, 5'd1};
    slot_ack[3] = 1'b1;
    tick();
    mmio_cs = 1'b0;
    mmio_rd = 1'b0;
    slot_ack[3] = 1'b0;
    chk("ws_slot_cs_c4", slot_cs, 64'h200);
    chk("ws_done_c4", 64'(mmio_done), 64'd0);
    slot_ack[9] = 1'b1;
    tick();
    slot_ack[9] = 1'b0;
    chk("ws_done_c5", 64'(mmio_done), 64'd1);
    chk("ws_err", 64'(mmio_err), 64'd0);
    chk("ws_rd_data_kept", 64'(mmio_rd_data), 64'h1234_5678);
    tick();
    chk("ws_idle_ready", 64'(mmio_ready), 64'd1);
    chk("ws_no_stray_cs", slot_cs, 64'h0);

    // Unpopulated write then read: slot 40
    request(1'b0, 6'd40, 5'd0, 32'hDEAD_BEEF);
    chk("up_wr_done_c1", 64'(mmio_done), 64'd1);
    chk("up_wr_no_strobe", slot_wr, 64'h0);
    chk("up_wr_no_cs", slot_cs, 64'h0);
    chk("up_wr_rd_data_kept", 64'(mmio_rd_data), 64'h1234_5678);
    tick();
    request(1'b1, 6'd40, 5'd0, 32'h0);
    chk("up_rd_done_c1", 64'(mmio_done), 64'd1);
    chk("up_rd_no_cs", slot_cs, 64'h0);
    chk("up_rd_data", 64'(mmio_rd_data), 64'hFFFF_FFFF);
    chk("up_rd_err", 64'(mmio_err), 64'd0);
    tick();

    // Illegal requests: rd=wr=1 and rd=wr=0 with cs
    mmio_cs = 1'b1; mmio_rd = 1'b1; mmio_wr = 1'b1; mmio_addr = {6'd3, 5'd0};
    tick();
    chk("ill_both_ready", 64'(mmio_ready), 64'd1);
    chk("ill_both_cs", slot_cs, 64'h0);
    mmio_rd = 1'b0; mmio_wr = 1'b0;
    tick();
    mmio_cs = 1'b0;
    chk("ill_none_ready", 64'(mmio_ready), 64'd1);
    chk("ill_none_done", 64'(mmio_done), 64'd0);

    // Timeout read of slot 0: done in cycle 18
    request(1'b1, 6'd0, 5'd0, 32'h0);
    repeat (16) tick();
    chk("to_done_c17", 64'(mmio_done), 64'd0);
    chk("to_cs_c17", slot_cs, 64'h1);
    tick();
    chk("to_done_c18", 64'(mmio_done), 64'd1);
    chk("to_err", 64'(mmio_err), 64'd1);
    chk("to_rd_data", 64'(mmio_rd_data), 64'hFFFF_FFFF);
    chk("to_err_count", 64'(err_count), 64'd1);
    tick();
    chk("to_err_cleared", 64'(mmio_err), 64'd0);

    // Ack in the final WAIT cycle wins over timeout
    request(1'b1, 6'd0, 5'd0, 32'h0);
    repeat (16) tick();
    slot_ack[0] = 1'b1;
    tick();
    slot_ack[0] = 1'b0;
    chk("ackwin_done", 64'(mmio_done), 64'd1);
    chk("ackwin_err", 64'(mmio_err), 64'd0);
    chk("ackwin_rd_data", 64'(mmio_rd_data), 64'hCAFE_0000);
    chk("ackwin_err_count", 64'(err_count), 64'd1);
    tick();

    // Saturation: 254 more timeouts reach 255, then keep going to 300 total
    repeat (254) timeout_read();
    chk("sat_count_255", 64'(err_count), 64'd255);
    repeat (45) timeout_read();
    chk("sat_count_held", 64'(err_count), 64'd255);

    // Asynchronous reset in the 2nd WAIT cycle
    request(1'b1, 6'd5, 5'd1, 32'h0);
    tick();
    tick();
    chk("rst_cs_before", slot_cs, 64'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_cs_async", slot_cs, 64'h0);
    chk("rst_ready", 64'(mmio_ready), 64'd1);
    chk("rst_rd_data", 64'(mmio_rd_data), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_reg_addr", 64'(slot_reg_addr), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    request(1'b1, 6'd5, 5'd1, 32'h0);
    chk("post_rst_rd_strobe", slot_rd, 64'h20);
    slot_ack[5] = 1'b1;
    tick();
    slot_ack[5] = 1'b0;
    chk("post_rst_done", 64'(mmio_done), 64'd1);
    chk("post_rst_rd_data", 64'(mmio_rd_data), 64'h5555_AAAA);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chu_mmio_bridge.md
# chu_mmio_bridge

Parametrised, registered MMIO bridge between the FPro bus and a configurable number of I/O slots. It is the successor to the combinational slot decoder. It adds a per-slot population mask, variable wait-state slots with an acknowledge handshake, a bus-timeout watchdog with error reporting, and a saturating error counter. It sits between the processor's MMIO port and the slot cores in the MMIO subsystem.

## Interface
Parameters:
- N_SLOT, 64: number of slots; power of 2, 2..64; SLOT_AW = log2(N_SLOT).
- REG_AW, 5: register address bits per slot.
- DW, 32: data width.
- SLOT_MASK, 64'h0000_0000_0000_03FF: bit i = 1 means slot i is populated.
- TIMEOUT, 16: WAIT cycles before a bus error; range 1..255.
- EMPTY_DATA, 32'hFFFF_FFFF: read value for unpopulated or timed-out slots.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mmio_cs  in  1  request strobe; sampled only when mmio_ready = 1.
- mmio_rd  in  1  read request.
- mmio_wr  in  1  write request.
- mmio_addr  in  SLOT_AW+REG_AW  address: {slot, reg}.
- mmio_wr_data  in  DW  write data.
- mmio_rd_data  out  DW  registered read data; held until the next read completes.
- mmio_ready  out  1  bridge idle, request accepted this cycle.
- mmio_done  out  1  one-cycle completion pulse.
- mmio_err  out  1  valid with mmio_done; 1 = timeout.
- err_count  out  8  saturating timeout counter.
- slot_cs  out  N_SLOT  one-hot slot select.
- slot_rd  out  N_SLOT  one-cycle read strobe.
- slot_wr  out  N_SLOT  one-cycle write strobe.
- slot_reg_addr  out  REG_AW  shared register address (latched).
- slot_wr_data  out  DW  shared write data (latched).
- slot_rd_data  in  N_SLOT*DW  flattened; slot i occupies bits [i*DW +: DW].
- slot_ack  in  N_SLOT  slot i completes access.

## Operation
The bridge runs a four-state machine: IDLE, ISSUE, WAIT, DONE.

- **IDLE.** mmio_ready = 1. A valid request is mmio_cs & (mmio_rd ^ mmio_wr).
  - Requests with both mmio_rd and mmio_wr high, or both low, are ignored.
  - On a valid request, latch the slot index, register address, write data and op.
  - Slot populated (SLOT_MASK bit = 1): go to ISSUE.
  - Slot unpopulated: go to DONE with err = 0. A read loads EMPTY_DATA; a write is discarded.
- **ISSUE** (exactly 1 cycle).
  - slot_cs[idx] = 1 and the matching slot_rd[idx] or slot_wr[idx] = 1.
  - If slot_ack[idx] = 1 in this cycle: capture the data (on a read) and go to DONE.
  - Otherwise clear the timer and go to WAIT.
- **WAIT.**
  - slot_cs[idx] stays 1; slot_rd and slot_wr are 0.
  - slot_ack[idx] = 1: capture the data (on a read) and go to DONE, err = 0.
  - Else, if timer == TIMEOUT-1: go to DONE, err = 1. A read loads EMPTY_DATA. err_count increments, saturating at 255.
  - Else: timer increments.
- **DONE** (1 cycle). mmio_done = 1, mmio_err is valid. Next state is IDLE.

General rules:
- slot_ack on any bit other than idx is ignored.
- Writes never alter mmio_rd_data.
- mmio_ready = 0 in every state except IDLE; requests arriving then are dropped, and the host must wait for ready.

## Timing
- Reset (asserted): state IDLE, mmio_ready 1, mmio_done 0, mmio_err 0, mmio_rd_data 0, err_count 0, all slot_* outputs 0, timer 0. The reset takes effect asynchronously, including mid-access; strobes drop immediately.
- Let cycle 0 be the acceptance edge. Completion then occurs as follows:
  - Unpopulated slot: done in cycle 1.
  - Zero-wait slot (ack in ISSUE): done in cycle 2.
  - Ack in the k-th WAIT cycle: done in cycle 2+k.
  - Timeout: done in cycle 2+TIMEOUT.
- If ack and timeout occur in the same cycle, ack wins: err = 0 and err_count is unchanged.
- mmio_rd_data updates on the edge entering DONE and is valid while mmio_done = 1.
- Back-to-back accesses: the next request is accepted in the cycle after DONE. Minimum issue rate is one access per 3 cycles.
- The address decode uses only the latched address, so mmio_addr may change after acceptance.

## Test plan
- **Zero-wait read.** Read slot 3, reg 5; slot 3 acks in ISSUE with data 32'h1234_5678. Required: slot_rd[3] high for 1 cycle, slot_reg_addr = 5, done in cycle 2, mmio_rd_data = 32'h1234_5678, err 0.
- **Wait-state write.** Write 32'hA5A5_0001 to slot 9, reg 2; ack 3 WAIT cycles later. Required: slot_wr[9] high for 1 cycle, slot_cs[9] held for 4 cycles, done in cycle 5, err 0, mmio_rd_data unchanged.
- **Timeout.** TIMEOUT = 16; read slot 0, which never acks. Required: done in cycle 18, err 1, rd_data 32'hFFFF_FFFF, err_count 1. Repeat 300 times: err_count saturates at 255. Ack landing in the final WAIT cycle: err 0, count unchanged.
- **Unpopulated slot.** Read slot 40. Required: no slot_cs asserted, done in cycle 1, rd_data 32'hFFFF_FFFF, err 0. Write to slot 40: no strobe, done, rd_data unchanged.
- **Illegal request.** mmio_cs with mmio_rd = mmio_wr = 1: no state change. Request during WAIT: ignored. Ack from a non-selected slot during WAIT: ignored.
- **Reset mid-operation.** Assert reset in the 2nd WAIT cycle. Required: slot_cs drops without waiting for a clock edge, and all outputs return to reset values. After reset release the next read completes normally.
